// File: rtl/mips_trace_capture.sv
// mips_trace_capture: records one (pc, alu) pair into a circular buffer each
// time the observed PC changes, then presents the pairs oldest-first over a
// valid/ready port once capture has stopped.
module mips_trace_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_alu,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ALMOST = (ADDR_W+1)'(DEPTH - 1);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_next;
  logic [ADDR_W-1:0]   r_rd_ptr, w_rd_ptr_next;
  logic [ADDR_W:0]     r_count, w_count_next;
  logic                r_overflow, w_overflow_next;
  logic                r_last_valid, w_last_valid_next;
  logic [DATA_W-1:0]   r_last_pc;

  logic [DATA_W-1:0]   r_mem_pc  [DEPTH];
  logic [DATA_W-1:0]   r_mem_alu [DEPTH];

  logic w_sample;
  logic w_write;
  logic w_transfer;

  // A new PC while capturing is a sample; it is written unless a non-wrapping
  // buffer is already full (which cannot persist, since filling ends capture).
  assign w_sample   = (r_state == S_CAPTURE) && (!r_last_valid || (pc_in != r_last_pc));
  assign w_write    = w_sample && ((r_count != FULL) || WRAP);
  assign rd_valid   = (r_state == S_DONE) && (r_count != '0);
  assign w_transfer = rd_valid && rd_ready;

  // Readout is combinational from the read pointer.
  assign rd_pc    = r_mem_pc[r_rd_ptr];
  assign rd_alu   = r_mem_alu[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state == S_CAPTURE);

  // Next-state and pointer/count bookkeeping.
  always_comb begin
    w_state_next      = r_state;
    w_wr_ptr_next     = r_wr_ptr;
    w_rd_ptr_next     = r_rd_ptr;
    w_count_next      = r_count;
    w_overflow_next   = r_overflow;
    w_last_valid_next = r_last_valid;

    unique case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_state_next      = S_CAPTURE;
          w_wr_ptr_next     = '0;
          w_rd_ptr_next     = '0;
          w_count_next      = '0;
          w_overflow_next   = 1'b0;
          w_last_valid_next = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (w_write) begin
          w_wr_ptr_next     = r_wr_ptr + 1'b1;
          w_last_valid_next = 1'b1;
          if (r_count == FULL) begin
            // Wrapping: the oldest entry is overwritten, so skip past it.
            w_rd_ptr_next   = r_rd_ptr + 1'b1;
            w_overflow_next = 1'b1;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
        // A coincident sample is still written above before leaving.
        if (stop || (!WRAP && w_write && (r_count == ALMOST))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) begin
          w_state_next      = S_CAPTURE;
          w_wr_ptr_next     = '0;
          w_rd_ptr_next     = '0;
          w_count_next      = '0;
          w_overflow_next   = 1'b0;
          w_last_valid_next = 1'b0;
        end else if (r_count == '0) begin
          w_state_next = S_IDLE;
        end else if (w_transfer) begin
          w_rd_ptr_next = r_rd_ptr + 1'b1;
          w_count_next  = r_count - 1'b1;
          if (r_count == (ADDR_W+1)'(1)) begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_last_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_count      <= w_count_next;
      r_overflow   <= w_overflow_next;
      r_last_valid <= w_last_valid_next;
    end
  end

  // Last stored PC; only meaningful while r_last_valid is set.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_last_pc <= pc_in;
    end
  end

  // Trace memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_write && !rst) begin
      r_mem_pc[r_wr_ptr]  <= pc_in;
      r_mem_alu[r_wr_ptr] <= alu_in;
    end
  end

endmodule
